norm_unit_serial: RTL
=====================

Name: norm_unit_serial

Overview:
- Parametrised attention-score normalizer.
- Sits between psum memory readback and psum memory write-back in fullchip.
- Accepts one row of `col` signed dot products and forms the absolute-value sum.
- Emits each |psum| divided by (sum >> SHIFT) using a shared multi-cycle restoring divider, under a valid/ready handshake on both sides.

Parameters:
- bw_psum, 19, width of one signed psum element
- col, 8, elements per row
- SHIFT, 7, right shift applied to the abs sum to form the divisor
- sum_bw, bw_psum+3, abs-sum accumulator width; must be at least bw_psum+clog2(col)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- in_valid  input  1  row on in_data is valid
- in_ready  output  1  block can accept a row
- in_data  input  bw_psum*col  signed psums; element i at [bw_psum*(i+1)-1 : bw_psum*i]
- out_valid  output  1  normalized row available
- out_ready  input  1  consumer accepts the row
- out_data  output  bw_psum*col  unsigned quotients, same packing as in_data
- sum_out  output  sum_bw  abs sum of the row in out_data
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: in_ready=0 during the reset cycle, out_valid=0, out_data=0, sum_out=0, busy=0, FSM=IDLE. Reset wins over every other input, including mid-SUM and mid-DIV; the in-flight row is discarded.
- Handshake: transfer occurs on an edge where valid and ready are both 1.
  - in_ready = (state==IDLE) && !reset.
  - out_valid stays high, and out_data/sum_out stay stable, until out_ready is sampled high.
  - in_valid while busy is ignored; no state change.
- FSM states: IDLE -> SUM -> DIV -> OUT -> IDLE.
- IDLE: on an input transfer, latch in_data into a row register, clear the accumulator, clear the element index, go to SUM.
- SUM: lasts exactly col cycles.
  - One element per cycle, index 0 to col-1.
  - abs = MSB ? (~x+1) : x, treated as an unsigned bw_psum value; the most-negative input maps to 2^(bw_psum-1) without overflow.
  - acc += zero-extended abs.
  - After element col-1, compute divisor = acc[sum_bw-1:SHIFT]. If that is 0, divisor = 1.
  - Go to DIV with index = 0.
- DIV: restoring radix-2 divider, exactly bw_psum cycles per element, elements 0..col-1 in order.
  - Dividend = abs of the element, recomputed from the row register.
  - Quotient truncated toward zero.
  - If the quotient exceeds 2^bw_psum-1, saturate to all ones.
  - Quotient is written into its out_data slot on the element's last cycle.
  - After element col-1: sum_out = acc, go to OUT.
- OUT: out_valid=1. On out_ready go to IDLE and drop out_valid the same edge. in_ready rises the cycle after.
- Latency: out_valid goes high on the edge col + col*bw_psum cycles after the accepting edge (160 cycles at defaults).
  - Minimum issue interval = col + col*bw_psum + 2 cycles when out_ready is held high.
- out_data keeps its previous row's values until it is overwritten element by element in DIV. Consumers must only sample it while out_valid=1.
- Simultaneous out_ready and in_valid in OUT: only the output transfer happens; the input waits for IDLE.
- busy is high exactly in SUM, DIV and OUT.

Test Plan:
- Uniform row: all 8 psums = 16 -> sum_out=128, divisor 1, every quotient 16; out_valid rises 160 edges after acceptance.
- Mixed signs: psums {-256, 256, 0, 0, 0, 0, 0, 0} -> sum_out=512, divisor 4, out_data elements {64, 64, 0, 0, 0, 0, 0, 0}.
- Zero guard: all psums 0 -> sum_out=0, divisor forced to 1, out_data=0. Also psums {100, 0, ...}: sum 100, divisor 1, q0=100.
- Extreme value: psum0 = -262144 (0x40000), others 0 -> abs 262144, sum_out=262144, divisor 2048, q0=128, rest 0.
- Backpressure and overlap:
  - Hold out_ready=0 for 5 cycles after out_valid -> out_data/sum_out stable and in_ready=0 throughout.
  - Pulse in_valid during DIV with a different row -> ignored; the first result is unchanged.
- Reset mid-DIV: assert reset for 1 cycle at the 40th DIV cycle -> next edge busy=0, out_valid=0, in_ready=1 the following cycle. A fresh row then produces the correct result with full latency.

Source files
------------

// File: rtl/norm_unit_serial.sv
// Row normalizer: forms the abs sum of one psum row, then divides each |psum|
// by (sum >> SHIFT) with a single shared restoring divider, one quotient bit per cycle.
module norm_unit_serial #(
  parameter int bw_psum = 19,
  parameter int col     = 8,
  parameter int SHIFT   = 7,
  parameter int sum_bw  = bw_psum + 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [bw_psum*col-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [bw_psum*col-1:0]   out_data,
  output logic [sum_bw-1:0]        sum_out,
  output logic                     busy
);

  localparam int IW = (col > 1) ? $clog2(col) : 1;
  localparam int CW = $clog2(bw_psum);
  localparam int DW = sum_bw - SHIFT;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUM  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [col-1:0][bw_psum-1:0]      row_q;
  logic [col-1:0][bw_psum-1:0]      abs_row;
  logic [col-1:0][bw_psum-1:0]      out_q;
  logic [sum_bw-1:0]                acc_q, acc_nx, sum_q;
  logic [IW-1:0]                    idx_q;
  logic [CW-1:0]                    cnt_q, bidx;
  logic [DW-1:0]                    div_q, div_nx, rem_q, rem_nx;
  logic [DW:0]                      rem_sh, rem_sub;
  logic [bw_psum-1:0]               q_q, q_nx, cur_abs;
  logic                             ge, last_el, last_bit;

  // Per-lane magnitude; unsigned negate maps the most-negative value to 2^(bw_psum-1).
  for (genvar g = 0; g < col; g++) begin : g_abs
    assign abs_row[g] = row_q[g][bw_psum-1] ? (-row_q[g]) : row_q[g];
  end

  assign cur_abs  = abs_row[idx_q];
  assign last_el  = (idx_q == IW'(col - 1));
  assign last_bit = (cnt_q == CW'(bw_psum - 1));

  assign acc_nx = acc_q + {{(sum_bw-bw_psum){1'b0}}, cur_abs};
  assign div_nx = (acc_nx[sum_bw-1:SHIFT] == '0) ? DW'(1) : acc_nx[sum_bw-1:SHIFT];

  // Restoring step: shift in the next dividend bit, MSB first.
  assign bidx    = CW'(bw_psum - 1) - cnt_q;
  assign rem_sh  = {rem_q, cur_abs[bidx]};
  assign rem_sub = rem_sh - {1'b0, div_q};
  assign ge      = (rem_sh >= {1'b0, div_q});
  assign rem_nx  = ge ? rem_sub[DW-1:0] : rem_sh[DW-1:0];
  // Quotient is as wide as the dividend and divisor >= 1, so it can never exceed all-ones.
  assign q_nx    = {q_q[bw_psum-2:0], ge};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid)             state_d = S_SUM;
      S_SUM:  if (last_el)              state_d = S_DIV;
      S_DIV:  if (last_el && last_bit)  state_d = S_OUT;
      S_OUT:  if (out_ready)            state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      out_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      div_q   <= DW'(1);
      rem_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (in_valid) begin
          row_q <= in_data;
          acc_q <= '0;
          idx_q <= '0;
        end
        S_SUM: begin
          acc_q <= acc_nx;
          if (last_el) begin
            div_q <= div_nx;
            idx_q <= '0;
            cnt_q <= '0;
            rem_q <= '0;
            q_q   <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DIV: begin
          if (last_bit) begin
            out_q[idx_q] <= q_nx;
            cnt_q        <= '0;
            rem_q        <= '0;
            q_q          <= '0;
            if (last_el) sum_q <= acc_q;
            else         idx_q <= idx_q + IW'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
            rem_q <= rem_nx;
            q_q   <= q_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_q;
  assign sum_out   = sum_q;

endmodule
